// File: rtl/cic_capture_ctrl.sv
// Capture sequencer for one PDM microphone channel: CIC reset/release, start-up
// transient discard, and a small FWFT FIFO toward the host bridge.
module cic_capture_ctrl #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned SETTLE_SAMPLES = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  enable,
  output logic                                  cic_rst_n,
  input  logic signed [DATA_WIDTH-1:0]          cic_dout,
  input  logic                                  cic_dout_valid,
  output logic        [DATA_WIDTH-1:0]          m_data,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic        [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                                  overflow,
  input  logic                                  clear_ovf,
  output logic        [1:0]                     state
);

  localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CNT_MAX     = (RST_CYCLES > SETTLE_SAMPLES) ? RST_CYCLES : SETTLE_SAMPLES;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
  localparam int unsigned RST_LAST    = RST_CYCLES - 1;
  localparam int unsigned SETTLE_LAST = (SETTLE_SAMPLES == 0) ? 0 : SETTLE_SAMPLES - 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESET_CIC = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    cic_rst_n_q, cic_rst_n_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];

  logic flush;
  logic push_req;
  logic full;
  logic pop;
  logic do_push;
  logic ovf_set;

  // Sequencer: next state, phase counter and registered CIC reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RESET_CIC;
          cnt_d   = '0;
          flush   = 1'b1;
        end
      end
      RESET_CIC: begin
        if (cnt_q == CNT_W'(RST_LAST)) begin
          cnt_d   = '0;
          state_d = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cic_dout_valid) begin
          if (cnt_q == CNT_W'(SETTLE_LAST)) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
    if ((state_q != IDLE) && !enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
    cic_rst_n_d = (state_d == SETTLE) || (state_d == RUN);
  end

  // FIFO control; the head register is loaded with next-cycle head so m_data is a flop.
  always_comb begin
    push_req = cic_dout_valid && (state_q == RUN);
    full     = (level_q == LVL_W'(FIFO_DEPTH));
    pop      = m_valid_q && m_ready;
    do_push  = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;

    wr_ptr_d = do_push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    level_d  = level_q;
    if (do_push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !do_push) begin
      level_d = level_q - LVL_W'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    m_valid_d = (level_d != '0);
    m_data_d  = (do_push && (wr_ptr_q == rd_ptr_d)) ? cic_dout : mem_q[rd_ptr_d];

    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cic_rst_n_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cic_rst_n_q <= cic_rst_n_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage array needs no reset: entries are only observed after being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= cic_dout;
    end
  end

  assign state      = state_q;
  assign cic_rst_n  = cic_rst_n_q;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_cic_capture_ctrl.sv
// Directed bench for cic_capture_ctrl: default build plus a SETTLE_SAMPLES=0 build.
module tb_cic_capture_ctrl;

  logic        clk;
  logic        rst_n;

  logic        enable, cic_rst_n, cic_dout_valid, m_valid, m_ready, overflow, clear_ovf;
  logic [15:0] cic_dout, m_data;
  logic [3:0]  fifo_level;
  logic [1:0]  state;

  logic        enable_b, cic_rst_n_b, valid_b, m_valid_b, m_ready_b, overflow_b, clear_b;
  logic [15:0] dout_b, m_data_b;
  logic [3:0]  level_b;
  logic [1:0]  state_b;

  int n_checks = 0;
  int n_pass   = 0;

  cic_capture_ctrl #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .RST_CYCLES(4), .SETTLE_SAMPLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cic_rst_n(cic_rst_n),
    .cic_dout(cic_dout), .cic_dout_valid(cic_dout_valid), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level),
    .overflow(overflow), .clear_ovf(clear_ovf), .state(state)
  );

  cic_capture_ctrl #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .RST_CYCLES(4), .SETTLE_SAMPLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .cic_rst_n(cic_rst_n_b),
    .cic_dout(dout_b), .cic_dout_valid(valid_b), .m_data(m_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .fifo_level(level_b),
    .overflow(overflow_b), .clear_ovf(clear_b), .state(state_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    cic_dout = v; cic_dout_valid = 1'b1;
    tick();
    cic_dout_valid = 1'b0;
  endtask

  // Enable from IDLE and feed the eight discarded settle pulses.
  task automatic go_run();
    enable = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 8; i++) push(16'hDEAD);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 0; cic_dout = 0; cic_dout_valid = 0; m_ready = 0; clear_ovf = 0;
    enable_b = 0; dout_b = 0; valid_b = 0; m_ready_b = 0; clear_b = 0;
    repeat (3) tick();
    n_checks++; if (state !== 2'd0) $display("FAIL rst_state: got %0d want 0", state); else n_pass++;
    n_checks++; if (cic_rst_n !== 1'b0) $display("FAIL rst_cic_rst_n: got %0b want 0", cic_rst_n); else n_pass++;
    n_checks++; if (m_data !== 16'h0) $display("FAIL rst_m_data: got %0h want 0", m_data); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++; if (state !== 2'd0) $display("FAIL idle_state: got %0d want 0", state); else n_pass++;
    n_checks++; if ({m_valid, fifo_level, overflow} !== 6'b0) $display("FAIL idle_fifo: got v=%0b l=%0d o=%0b want 0/0/0", m_valid, fifo_level, overflow); else n_pass++;
  endtask

  task automatic test_startup();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (state !== 2'd1 || cic_rst_n !== 1'b0) $display("FAIL startup_rst%0d: got s=%0d c=%0b want s=1 c=0", i, state, cic_rst_n); else n_pass++;
    end
    tick();
    n_checks++; if (state !== 2'd2 || cic_rst_n !== 1'b1) $display("FAIL startup_settle: got s=%0d c=%0b want s=2 c=1", state, cic_rst_n); else n_pass++;
  endtask

  task automatic test_settle();
    for (int v = 1; v <= 10; v++) begin
      push(16'(v));
      if (v == 7) begin
        n_checks++; if (state !== 2'd2 || fifo_level !== 4'd0) $display("FAIL settle_p7: got s=%0d l=%0d want s=2 l=0", state, fifo_level); else n_pass++;
      end
      if (v == 8) begin
        n_checks++; if (state !== 2'd3 || fifo_level !== 4'd0 || cic_rst_n !== 1'b1) $display("FAIL settle_p8: got s=%0d l=%0d want s=3 l=0", state, fifo_level); else n_pass++;
      end
      if (v == 9) begin
        n_checks++; if (m_valid !== 1'b1 || m_data !== 16'd9) $display("FAIL settle_p9: got v=%0b d=%0d want v=1 d=9", m_valid, m_data); else n_pass++;
      end
      tick();
    end
    n_checks++; if (fifo_level !== 4'd2 || m_data !== 16'd9) $display("FAIL settle_hold: got l=%0d d=%0d want l=2 d=9", fifo_level, m_data); else n_pass++;
    m_ready = 1'b1;
    tick();
    n_checks++; if (fifo_level !== 4'd1 || m_data !== 16'd10) $display("FAIL settle_rd1: got l=%0d d=%0d want l=1 d=10", fifo_level, m_data); else n_pass++;
    tick();
    n_checks++; if (m_valid !== 1'b0 || fifo_level !== 4'd0) $display("FAIL settle_rd2: got v=%0b l=%0d want 0/0", m_valid, fifo_level); else n_pass++;
    m_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [15:0] exp [8];
    exp = '{16'd101, 16'd102, 16'd103, 16'd104, 16'd105, 16'd106, 16'd107, 16'd109};
    for (int i = 0; i < 9; i++) begin
      push(16'(100 + i));
      if (i == 7) begin
        n_checks++; if (fifo_level !== 4'd8 || overflow !== 1'b0) $display("FAIL ovf_full: got l=%0d o=%0b want l=8 o=0", fifo_level, overflow); else n_pass++;
      end
    end
    n_checks++; if (fifo_level !== 4'd8 || overflow !== 1'b1) $display("FAIL ovf_set: got l=%0d o=%0b want l=8 o=1", fifo_level, overflow); else n_pass++;
    clear_ovf = 1'b1;
    push(16'd200);
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins: got %0b want 1", overflow); else n_pass++;
    tick();
    clear_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %0b want 0", overflow); else n_pass++;
    m_ready = 1'b1;
    push(16'd109);
    m_ready = 1'b0;
    n_checks++; if (fifo_level !== 4'd8 || overflow !== 1'b0 || m_data !== 16'd101) $display("FAIL ovf_pushpop: got l=%0d o=%0b d=%0d want 8/0/101", fifo_level, overflow, m_data); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (m_valid !== 1'b1 || m_data !== exp[k]) $display("FAIL ovf_drain%0d: got v=%0b d=%0d want v=1 d=%0d", k, m_valid, m_data, exp[k]); else n_pass++;
      m_ready = 1'b1;
      tick();
    end
    m_ready = 1'b0;
    n_checks++; if (m_valid !== 1'b0 || fifo_level !== 4'd0) $display("FAIL ovf_empty: got v=%0b l=%0d want 0/0", m_valid, fifo_level); else n_pass++;
  endtask

  task automatic test_backpressure();
    push(16'h11); push(16'h22); push(16'h33);
    n_checks++; if (fifo_level !== 4'd3 || m_data !== 16'h11) $display("FAIL bp_fill: got l=%0d d=%0h want 3/11", fifo_level, m_data); else n_pass++;
    m_ready = 1'b1; tick();
    n_checks++; if (fifo_level !== 4'd2 || m_data !== 16'h22) $display("FAIL bp_pop1: got l=%0d d=%0h want 2/22", fifo_level, m_data); else n_pass++;
    m_ready = 1'b0; tick();
    n_checks++; if (fifo_level !== 4'd2 || m_data !== 16'h22) $display("FAIL bp_hold: got l=%0d d=%0h want 2/22", fifo_level, m_data); else n_pass++;
    m_ready = 1'b1; tick();
    n_checks++; if (fifo_level !== 4'd1 || m_data !== 16'h33) $display("FAIL bp_pop2: got l=%0d d=%0h want 1/33", fifo_level, m_data); else n_pass++;
    tick();
    m_ready = 1'b0;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL bp_empty: got v=%0b want 0", m_valid); else n_pass++;
  endtask

  task automatic test_disable();
    for (int i = 0; i < 5; i++) push(16'(16'h50 + i));
    n_checks++; if (fifo_level !== 4'd5) $display("FAIL dis_fill: got l=%0d want 5", fifo_level); else n_pass++;
    enable = 1'b0;
    push(16'h55);
    n_checks++; if (fifo_level !== 4'd6 || state !== 2'd0 || cic_rst_n !== 1'b0) $display("FAIL dis_last: got l=%0d s=%0d c=%0b want 6/0/0", fifo_level, state, cic_rst_n); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (m_valid !== 1'b1 || m_data !== 16'(16'h50 + k)) $display("FAIL dis_drain%0d: got v=%0b d=%0h want v=1 d=%0h", k, m_valid, m_data, 16'h50 + k); else n_pass++;
      m_ready = 1'b1;
      tick();
    end
    m_ready = 1'b0;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL dis_empty: got v=%0b want 0", m_valid); else n_pass++;
    go_run();
    n_checks++; if (state !== 2'd3) $display("FAIL dis_rerun: got s=%0d want 3", state); else n_pass++;
    push(16'h60); push(16'h61); push(16'h62);
    enable = 1'b0; tick();
    n_checks++; if (state !== 2'd0 || fifo_level !== 4'd3) $display("FAIL dis_keep: got s=%0d l=%0d want 0/3", state, fifo_level); else n_pass++;
    enable = 1'b1; tick();
    n_checks++; if (state !== 2'd1 || fifo_level !== 4'd0 || m_valid !== 1'b0) $display("FAIL dis_flush: got s=%0d l=%0d v=%0b want 1/0/0", state, fifo_level, m_valid); else n_pass++;
  endtask

  task automatic test_settle0();
    enable_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (state_b !== 2'd1) $display("FAIL s0_rst%0d: got s=%0d want 1", i, state_b); else n_pass++;
    end
    tick();
    n_checks++; if (state_b !== 2'd3 || cic_rst_n_b !== 1'b1) $display("FAIL s0_run: got s=%0d c=%0b want 3/1", state_b, cic_rst_n_b); else n_pass++;
    dout_b = 16'h1234; valid_b = 1'b1; tick(); valid_b = 1'b0;
    n_checks++; if (level_b !== 4'd1 || m_valid_b !== 1'b1 || m_data_b !== 16'h1234) $display("FAIL s0_push: got l=%0d v=%0b d=%0h want 1/1/1234", level_b, m_valid_b, m_data_b); else n_pass++;
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (state_b !== 2'd0 || level_b !== 4'd0 || cic_rst_n_b !== 1'b0 || m_valid_b !== 1'b0) $display("FAIL async_rst: got s=%0d l=%0d c=%0b v=%0b want 0/0/0/0", state_b, level_b, cic_rst_n_b, m_valid_b); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_settle();
    test_overflow();
    test_backpressure();
    test_disable();
    test_settle0();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
